ram_explorer: RTL and testbench
===============================

# ram_explorer

Board-level front end for exploring a parametrised simple dual-port RAM using slide switches, two push buttons and six seven-segment digits. Switch-selected registers hold write data, read address and write address. Writes are committed only on a button press, and the write address auto-increments. Two background engines are added: a read-address scan and a whole-memory fill.

## Interface
Parameters:
- DATA_WIDTH, 8: memory word width, legal range 1..8; display zero-extends.
- ADDR_WIDTH, 4: address width, legal range 1..4; depth is 2^ADDR_WIDTH.
- SCAN_DIV, 50_000_000: clk cycles per read-address step in scan mode, minimum 2.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- SW, input, 10: SW[9:8] is the mode; SW[7:0] is the value.
- KEY, input, 2: raw buttons, active-low, already debounced upstream, asynchronous to clk.
- HEX0..HEX5, output, 8 each: active-low digits. Bits [6:0] are gfedcba and bit 7 is the decimal point.
- busy, output, 1: high while a fill is in progress.
- scan_on, output, 1: high while scan mode is enabled.

## Operation
**Modes (SW[9:8]):**
- 00 DATA: KEY0 press loads din from SW[DATA_WIDTH-1:0].
- 01 RADDR: KEY0 press loads raddr from SW[ADDR_WIDTH-1:0].
- 10 WADDR: KEY0 press loads waddr from SW[ADDR_WIDTH-1:0].
- 11 RUN: KEY0 press writes mem[waddr] <= din, then waddr <= waddr+1, wrapping modulo depth.

**KEY1 press:**
- In mode 11, starts a FILL.
- In modes 00, 01 and 10, toggles scan_on.

**Button inputs:** each KEY has a 2-flop synchroniser plus one history flop. A press is a 1-cycle pulse on a high-to-low transition of the synchronised value. Holding a button produces exactly one press.

**Scan engine:**
- A counter runs 0..SCAN_DIV-1. On terminal count, raddr increments (wrapping) and the counter returns to 0.
- The counter clears when scan_on rises and whenever raddr is loaded by KEY0. A KEY0 load takes priority over a scan step in the same cycle.
- Clearing scan_on holds raddr at its current value.

**FSM (states IDLE, FILL):**
- IDLE -> FILL on a KEY1 press in mode 11. faddr <= 0 and busy <= 1.
- In FILL, each cycle writes mem[faddr] <= din and increments faddr.
- When faddr = depth-1, that write completes, the FSM returns to IDLE and busy <= 0.
- A fill lasts exactly 2^ADDR_WIDTH cycles.
- During FILL, all KEY presses are discarded. SW changes, din, waddr and raddr loads are all ignored. The scan engine keeps running.

**Memory:**
- Synchronous write, registered read: dout <= mem[raddr] every cycle.
- A read and a write to the same address in the same cycle returns the old data.
- Memory contents are not reset.

**Display:**
- HEX1:HEX0 show din.
- HEX3:HEX2 show dout.
- HEX4 shows raddr.
- HEX5 shows waddr.
- Standard hex glyphs, for example 0 = 7'b1000000, A = 7'b0001000, F = 7'b0001110.

**Decimal points (bit 7):** a digit's point is lit (0) when its register is the one selected by the mode; otherwise it is 1.
- Mode 00 lights HEX0 and HEX1.
- Mode 01 lights HEX4.
- Mode 10 lights HEX5.
- Mode 11 lights HEX2 and HEX3.

## Timing
- **Reset values:** din, raddr, waddr, dout, faddr and the scan counter = 0; FSM = IDLE; busy = 0; scan_on = 0; synchroniser flops = 1.
  - This gives HEX0..HEX5[6:0] = 7'b1000000 out of reset.
  - Decimal points follow SW combinationally.
- **Press latency:** KEY sampled low at edge k produces the press pulse in the cycle after edge k+1. The target register or memory updates at edge k+2.
- **Read latency:** one cycle. raddr changing at edge e shows in dout after edge e+1.
- **Write-then-read:** data written at edge w is readable at the same address at edge w+1 and visible in dout after edge w+1.
- **Waddr wrap:** a RUN write at waddr = depth-1 sets waddr to 0.
- **Reset mid-fill:** returns to IDLE immediately and busy drops asynchronously. Already-written locations keep their data; the rest keep their old contents.
- **Scan step:** occurs exactly SCAN_DIV cycles after the counter clears, then every SCAN_DIV cycles.

## Test plan
- **Reset:** hold rst_n = 0 with random SW. Required: all HEX[6:0] = 7'b1000000, busy = 0, scan_on = 0. Mode 00 gives HEX0[7] = HEX1[7] = 0 and the rest 1.
- **Write/read:**
  - Load din = 8'hA5 (mode 00) and waddr = 3 (mode 10), then press KEY0 in mode 11.
  - Load raddr = 3 (mode 01).
  - Required: HEX3/HEX2 show A/5 and HEX5 shows 4.
- **Auto-increment wrap:** waddr = 15, din = 8'h3C, press KEY0 in mode 11 twice. Required: mem[15] = mem[0] = 8'h3C and waddr = 1.
- **Fill:**
  - din = 8'h77; press KEY1 in mode 11.
  - Required: busy is high for exactly 16 cycles and a KEY0 press during the fill has no effect.
  - Afterwards, every raddr 0..15 reads 8'h77 and waddr is unchanged.
- **Scan:**
  - With SCAN_DIV = 4 and raddr = 14, press KEY1 in mode 00.
  - Required: raddr steps 14 -> 15 -> 0 every 4 cycles.
  - A KEY0 load to raddr = 5 in mode 01 restarts the count. The next step to 6 occurs 4 cycles later.
- **Reset mid-fill:**
  - Preload all words with 8'h11. Set din = 8'h22, start a fill, and assert rst_n after 5 fill cycles.
  - Required: busy = 0 immediately, addresses 0..4 read 8'h22 and addresses 5..15 read 8'h11.

Source files
------------

// File: rtl/ram_explorer.sv
// rtl/ram_explorer.sv - switch/button front end for a simple dual-port RAM with scan and fill engines
module ram_explorer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int SCAN_DIV   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic       busy,
  output logic       scan_on
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(SCAN_DIV - 1);

  localparam logic [1:0] MODE_DATA  = 2'b00;
  localparam logic [1:0] MODE_RADDR = 2'b01;
  localparam logic [1:0] MODE_WADDR = 2'b10;
  localparam logic [1:0] MODE_RUN   = 2'b11;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_faddr;
  logic                    r_busy;
  logic [1:0]              r_key_s1;
  logic [1:0]              r_key_s2;
  logic [1:0]              r_key_hist;
  logic [DATA_WIDTH-1:0]   r_din;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [ADDR_WIDTH-1:0]   r_raddr;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_scan_on;
  logic [CNT_W-1:0]        r_scan_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [1:0]              w_mode;
  logic [1:0]              w_press;
  logic                    w_idle;
  logic                    w_p0;
  logic                    w_p1;
  logic                    w_raddr_load;
  logic                    w_scan_toggle;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [7:0]              w_din8;
  logic [7:0]              w_dout8;
  logic [3:0]              w_raddr4;
  logic [3:0]              w_waddr4;

  // Buttons are active-low, so a press is the falling edge of the synchronised level.
  // Presses are ignored entirely while a fill owns the write port.
  assign w_mode        = SW[9:8];
  assign w_press       = r_key_hist & ~r_key_s2;
  assign w_idle        = (r_state == S_IDLE);
  assign w_p0          = w_press[0] & w_idle;
  assign w_p1          = w_press[1] & w_idle;
  assign w_raddr_load  = w_p0 && (w_mode == MODE_RADDR);
  assign w_scan_toggle = w_p1 && (w_mode != MODE_RUN);
  assign w_we          = (r_state == S_FILL) || (w_p0 && (w_mode == MODE_RUN));
  assign w_wr_addr     = (r_state == S_FILL) ? r_faddr : r_waddr;

  assign busy    = r_busy;
  assign scan_on = r_scan_on;

  // Two-flop synchroniser plus history flop per button; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1   <= 2'b11;
      r_key_s2   <= 2'b11;
      r_key_hist <= 2'b11;
    end else begin
      r_key_s1   <= KEY;
      r_key_s2   <= r_key_s1;
      r_key_hist <= r_key_s2;
    end
  end

  // Fill sequencer: one word per cycle from address 0 up to the last, then back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_faddr <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_p1 && (w_mode == MODE_RUN)) begin
            r_state <= S_FILL;
            r_faddr <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_FILL: begin
          r_faddr <= r_faddr + 1'b1;
          if (r_faddr == LAST_ADDR) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write-side registers: data word and auto-incrementing write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din   <= '0;
      r_waddr <= '0;
    end else if (w_p0) begin
      case (w_mode)
        MODE_DATA:  r_din   <= SW[DATA_WIDTH-1:0];
        MODE_WADDR: r_waddr <= SW[ADDR_WIDTH-1:0];
        MODE_RUN:   r_waddr <= r_waddr + 1'b1;
        default:    r_waddr <= r_waddr;
      endcase
    end
  end

  // Read address: a manual load wins over a scan step and restarts the step timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr    <= '0;
      r_scan_on  <= 1'b0;
      r_scan_cnt <= '0;
    end else begin
      if (w_scan_toggle) begin
        r_scan_on <= ~r_scan_on;
      end
      if (w_raddr_load) begin
        r_raddr    <= SW[ADDR_WIDTH-1:0];
        r_scan_cnt <= '0;
      end else if (w_scan_toggle && !r_scan_on) begin
        r_scan_cnt <= '0;
      end else if (r_scan_on) begin
        if (r_scan_cnt == LAST_CNT) begin
          r_scan_cnt <= '0;
          r_raddr    <= r_raddr + 1'b1;
        end else begin
          r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Storage array is deliberately not reset; a reset mid-fill leaves unwritten words intact.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_addr] <= r_din;
    end
  end

  // Registered read; a same-address write in the same cycle returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else begin
      r_dout <= r_mem[r_raddr];
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign w_din8   = 8'(r_din);
  assign w_dout8  = 8'(r_dout);
  assign w_raddr4 = 4'(r_raddr);
  assign w_waddr4 = 4'(r_waddr);

  // Digits with the decimal point marking the register the current mode edits.
  always_comb begin
    HEX0 = {~(w_mode == MODE_DATA),  hex7(w_din8[3:0])};
    HEX1 = {~(w_mode == MODE_DATA),  hex7(w_din8[7:4])};
    HEX2 = {~(w_mode == MODE_RUN),   hex7(w_dout8[3:0])};
    HEX3 = {~(w_mode == MODE_RUN),   hex7(w_dout8[7:4])};
    HEX4 = {~(w_mode == MODE_RADDR), hex7(w_raddr4)};
    HEX5 = {~(w_mode == MODE_WADDR), hex7(w_waddr4)};
  end

endmodule

// File: tb/tb_ram_explorer.sv
// tb/tb_ram_explorer.sv - scoreboard bench for ram_explorer
module tb_ram_explorer;

  logic       clk;
  logic       rst_n;
  logic [9:0] SW;
  logic [1:0] KEY;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       busy;
  logic       scan_on;
  logic [7:0] hx [6];

  int total;
  int bad;

  logic [7:0] exp_q [$];
  logic [7:0] mem_m [16];
  logic [7:0] din_m;
  logic [3:0] wa_m;
  logic [3:0] ra_m;

  ram_explorer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .KEY(KEY),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .busy(busy), .scan_on(scan_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    hx[0] = HEX0; hx[1] = HEX1; hx[2] = HEX2;
    hx[3] = HEX3; hx[4] = HEX4; hx[5] = HEX5;
  end

  // Glyph decoder; unknown patterns map to 99 so they never match a nibble.
  function automatic int seg2nib(input logic [6:0] s);
    case (s)
      7'h40: return 0;  7'h79: return 1;  7'h24: return 2;  7'h30: return 3;
      7'h19: return 4;  7'h12: return 5;  7'h02: return 6;  7'h78: return 7;
      7'h00: return 8;  7'h10: return 9;  7'h08: return 10; 7'h03: return 11;
      7'h46: return 12; 7'h21: return 13; 7'h06: return 14; 7'h0E: return 15;
      default: return 99;
    endcase
  endfunction

  function automatic int dout_obs();
    return seg2nib(HEX3[6:0]) * 16 + seg2nib(HEX2[6:0]);
  endfunction

  function automatic int din_obs();
    return seg2nib(HEX1[6:0]) * 16 + seg2nib(HEX0[6:0]);
  endfunction

  function automatic logic dp_exp(input int m, input int i);
    logic lit;
    case (m)
      0: lit = (i == 0) || (i == 1);
      1: lit = (i == 4);
      2: lit = (i == 5);
      default: lit = (i == 2) || (i == 3);
    endcase
    return ~lit;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int idx);
    KEY[idx] = 1'b0;
    repeat (4) tick();
    KEY[idx] = 1'b1;
    repeat (4) tick();
  endtask

  task automatic load(input logic [1:0] m, input logic [7:0] v);
    SW = {m, v};
    press_key(0);
  endtask

  task automatic issue_read(input logic [3:0] a);
    exp_q.push_back(mem_m[a]);
    ra_m = a;
    load(2'b01, {4'h0, a});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    KEY = 2'b11;
    SW = {2'b00, 8'($urandom)};
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (hx[i][6:0] !== 7'b1000000) begin
        bad++;
        $display("FAIL reset_glyph HEX%0d got=%b exp=%b", i, hx[i][6:0], 7'b1000000);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (scan_on !== 1'b0) begin bad++; $display("FAIL reset_scan_on got=%b exp=0", scan_on); end
    for (int m = 0; m < 4; m++) begin
      SW = {2'(m), 8'($urandom)};
      #1;
      for (int i = 0; i < 6; i++) begin
        total++;
        if (hx[i][7] !== dp_exp(m, i)) begin
          bad++;
          $display("FAIL reset_dp mode=%0d HEX%0d got=%b exp=%b", m, i, hx[i][7], dp_exp(m, i));
        end
      end
    end
    SW = '0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    din_m = 8'h00; wa_m = 4'h0; ra_m = 4'h0;
  endtask

  task automatic test_write_read();
    logic [7:0] expv;
    int got;
    load(2'b00, 8'hA5); din_m = 8'hA5;
    total++;
    if (din_obs() !== int'(din_m)) begin bad++; $display("FAIL wr_din got=%0h exp=%0h", din_obs(), din_m); end
    load(2'b10, 8'h03); wa_m = 4'h3;
    total++;
    if (seg2nib(HEX5[6:0]) !== int'(wa_m)) begin bad++; $display("FAIL wr_waddr got=%0d exp=%0d", seg2nib(HEX5[6:0]), wa_m); end
    load(2'b11, 8'h00); mem_m[wa_m] = din_m; wa_m = wa_m + 4'h1;
    total++;
    if (seg2nib(HEX5[6:0]) !== int'(wa_m)) begin bad++; $display("FAIL wr_waddr_inc got=%0d exp=%0d", seg2nib(HEX5[6:0]), wa_m); end
    issue_read(4'h3);
    got = dout_obs(); expv = exp_q.pop_front();
    total++;
    if (got !== int'(expv)) begin bad++; $display("FAIL wr_read3 got=%0h exp=%0h", got, expv); end
    total++;
    if (seg2nib(HEX4[6:0]) !== int'(ra_m)) begin bad++; $display("FAIL wr_raddr got=%0d exp=%0d", seg2nib(HEX4[6:0]), ra_m); end
    total++;
    if ({HEX4[7], HEX2[7]} !== 2'b01) begin bad++; $display("FAIL wr_dp_mode1 got=%b exp=01", {HEX4[7], HEX2[7]}); end
    SW = {2'b11, 8'h00};
    #1;
    total++;
    if ({HEX3[7], HEX2[7], HEX4[7]} !== 3'b001) begin bad++; $display("FAIL wr_dp_mode3 got=%b exp=001", {HEX3[7], HEX2[7], HEX4[7]}); end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] expv;
    int got;
    load(2'b10, 8'h0F); wa_m = 4'hF;
    load(2'b00, 8'h3C); din_m = 8'h3C;
    for (int k = 0; k < 2; k++) begin
      load(2'b11, 8'h00);
      mem_m[wa_m] = din_m;
      wa_m = wa_m + 4'h1;
    end
    total++;
    if (seg2nib(HEX5[6:0]) !== int'(wa_m)) begin bad++; $display("FAIL wrap_waddr got=%0d exp=%0d", seg2nib(HEX5[6:0]), wa_m); end
    issue_read(4'hF);
    got = dout_obs(); expv = exp_q.pop_front();
    total++;
    if (got !== int'(expv)) begin bad++; $display("FAIL wrap_read15 got=%0h exp=%0h", got, expv); end
    issue_read(4'h0);
    got = dout_obs(); expv = exp_q.pop_front();
    total++;
    if (got !== int'(expv)) begin bad++; $display("FAIL wrap_read0 got=%0h exp=%0h", got, expv); end
  endtask

  task automatic test_fill();
    logic [7:0] expv;
    int got;
    int n;
    bit seen;
    load(2'b00, 8'h77); din_m = 8'h77;
    SW = {2'b11, 8'h00};
    KEY[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) begin seen = 1; break; end
    end
    n = 0;
    if (seen) begin
      n = 1;
      KEY[0] = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (busy === 1'b1) n++;
        else break;
      end
    end
    KEY = 2'b11;
    repeat (4) tick();
    total++;
    if (n != 16) begin bad++; $display("FAIL fill_busy_cycles got=%0d exp=16", n); end
    for (int a = 0; a < 16; a++) mem_m[a] = din_m;
    total++;
    if (seg2nib(HEX5[6:0]) !== int'(wa_m)) begin bad++; $display("FAIL fill_waddr got=%0d exp=%0d", seg2nib(HEX5[6:0]), wa_m); end
    total++;
    if (din_obs() !== int'(din_m)) begin bad++; $display("FAIL fill_din got=%0h exp=%0h", din_obs(), din_m); end
    for (int a = 0; a < 16; a++) begin
      issue_read(4'(a));
      got = dout_obs(); expv = exp_q.pop_front();
      total++;
      if (got !== int'(expv)) begin bad++; $display("FAIL fill_read[%0d] got=%0h exp=%0h", a, got, expv); end
    end
  endtask

  task automatic test_scan();
    int expr;
    bit seen;
    load(2'b01, 8'h0E); ra_m = 4'hE;
    SW = {2'b00, 8'h00};
    KEY[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (scan_on === 1'b1) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL scan_start got=%b exp=1", scan_on); end
    for (int t = 0; t < 16; t++) begin
      if (t > 0) tick();
      if (t < 4) expr = 14;
      else if (t < 8) expr = 15;
      else if (t < 11) expr = 0;
      else if (t < 15) expr = 5;
      else expr = 6;
      total++;
      if (seg2nib(HEX4[6:0]) !== expr) begin
        bad++;
        $display("FAIL scan_step t=%0d got=%0d exp=%0d", t, seg2nib(HEX4[6:0]), expr);
      end
      if (t == 2) KEY[1] = 1'b1;
      if (t == 8) begin
        SW = {2'b01, 8'h05};
        KEY[0] = 1'b0;
      end
    end
    KEY[0] = 1'b1;
    total++;
    if (scan_on !== 1'b1) begin bad++; $display("FAIL scan_still_on got=%b exp=1", scan_on); end
    SW = {2'b00, 8'h00};
    press_key(1);
    repeat (10) tick();
    total++;
    if (scan_on !== 1'b0) begin bad++; $display("FAIL scan_off got=%b exp=0", scan_on); end
    total++;
    if (seg2nib(HEX4[6:0]) !== 6) begin bad++; $display("FAIL scan_hold got=%0d exp=6", seg2nib(HEX4[6:0])); end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] expv;
    int got;
    bit seen;
    load(2'b00, 8'h11); din_m = 8'h11;
    SW = {2'b11, 8'h00};
    KEY[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) begin seen = 1; break; end
    end
    KEY[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      tick();
    end
    total++;
    if (!seen || busy !== 1'b0) begin bad++; $display("FAIL rmf_preload seen=%0d busy=%b exp=1,0", seen, busy); end
    for (int a = 0; a < 16; a++) mem_m[a] = 8'h11;
    repeat (4) tick();
    load(2'b00, 8'h22); din_m = 8'h22;
    SW = {2'b11, 8'h00};
    KEY[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) begin seen = 1; break; end
    end
    KEY[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (!seen || busy !== 1'b0) begin bad++; $display("FAIL rmf_busy_async seen=%0d busy=%b exp=1,0", seen, busy); end
    for (int a = 0; a < 5; a++) mem_m[a] = 8'h22;
    SW = '0;
    KEY = 2'b11;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    din_m = 8'h00; wa_m = 4'h0; ra_m = 4'h0;
    for (int a = 0; a < 16; a++) begin
      issue_read(4'(a));
      got = dout_obs(); expv = exp_q.pop_front();
      total++;
      if (got !== int'(expv)) begin bad++; $display("FAIL rmf_read[%0d] got=%0h exp=%0h", a, got, expv); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    SW = '0;
    KEY = 2'b11;
    test_reset();
    test_write_read();
    test_wrap();
    test_fill();
    test_scan();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
